ecp5pll_phase_ctrl: RTL

Sequencer for the ECP5 PLL dynamic phase-shift port. It accepts "shift output N by K steps in direction D" requests over a valid/ready handshake. It drives phasesel/phasedir/phasestep with guaranteed setup, pulse and gap timing, and stalls while the PLL is unlocked. It sits between user logic (e.g. DDR/video clock alignment) and the ecp5pll instance built with dynamic_en=1.

---
 rtl/ecp5pll_phase_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl: sequences ECP5 PLL dynamic phase steps with setup/pulse/gap timing and lock stalls.
// Define ECP5PLL_PHASE_TRACK_EN to keep per-output step position counters on pos0..pos3.
module ecp5pll_phase_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8,
    parameter int CNT_W     = 8,
    parameter int POS_W     = 10
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_cnt,
    output logic             busy,
    output logic             done,
    input  logic             locked,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             phaseloadreg,
    output logic [POS_W-1:0] pos0,
    output logic [POS_W-1:0] pos1,
    output logic [POS_W-1:0] pos2,
    output logic [POS_W-1:0] pos3
);
    localparam int TMAX = (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                                                  : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STEP_HI, STEP_LO, DONE} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic             accept, last;

    assign req_ready    = (state == IDLE) && locked;
    assign accept       = req_valid && req_ready;
    assign last         = timer == TW'(1);
    assign phaseloadreg = 1'b0;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        rem_nx   = rem;
        case (state)
            IDLE: if (accept) begin
                state_nx = SETUP;
                timer_nx = TW'(SETUP_CYC);
                rem_nx   = req_cnt;
            end
            SETUP, STEP_LO: if (locked) begin
                state_nx = last ? ((rem == '0) ? DONE : STEP_HI) : state;
                timer_nx = last ? TW'(PULSE_CYC) : timer - TW'(1);
            end
            // A pulse in progress always completes, regardless of lock.
            STEP_HI: begin
                state_nx = last ? STEP_LO : STEP_HI;
                timer_nx = last ? TW'(GAP_CYC) : timer - TW'(1);
                rem_nx   = last ? rem - CNT_W'(rem != '0) : rem;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phasestep <= 1'b0;
            phasesel  <= '0;
            phasedir  <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            rem       <= rem_nx;
            busy      <= state_nx != IDLE;
            done      <= state_nx == DONE;
            phasestep <= state_nx == STEP_HI;
            phasesel  <= accept ? req_sel : phasesel;
            phasedir  <= accept ? req_dir : phasedir;
        end
    end

`ifdef ECP5PLL_PHASE_TRACK_EN
    logic [POS_W-1:0] pos [4];
    logic             step_end;

    assign step_end = (state == STEP_HI) && last;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) pos[i] <= '0;
        end else if (step_end) begin
            pos[phasesel] <= phasedir ? pos[phasesel] + POS_W'(1) : pos[phasesel] - POS_W'(1);
        end
    end

    assign pos0 = pos[0];
    assign pos1 = pos[1];
    assign pos2 = pos[2];
    assign pos3 = pos[3];
`else
    assign pos0 = '0;
    assign pos1 = '0;
    assign pos2 = '0;
    assign pos3 = '0;
`endif
endmodule
